// File: rtl/aref_sched_if.sv
// Refresh-scheduler bus: arbiter handshake and the DDR2 command pins the scheduler drives
// while it owns the bus.
interface aref_sched_if #(
  parameter int RANKS     = 1,
  parameter int ADDR_BITS = 13,
  parameter int BA_BITS   = 3
);
  logic                 aref_gnt;
  logic                 aref_req;
  logic                 aref_urgent;
  logic                 aref_busy;
  logic                 aref_end;
  logic [RANKS-1:0]     aref_cs_n;
  logic                 aref_ras_n;
  logic                 aref_cas_n;
  logic                 aref_we_n;
  logic [BA_BITS-1:0]   aref_ba;
  logic [ADDR_BITS-1:0] aref_addr;

  modport master (
    input  aref_gnt,
    output aref_req, aref_urgent, aref_busy, aref_end,
    output aref_cs_n, aref_ras_n, aref_cas_n, aref_we_n, aref_ba, aref_addr
  );

  modport slave (
    output aref_gnt,
    input  aref_req, aref_urgent, aref_busy, aref_end,
    input  aref_cs_n, aref_ras_n, aref_cas_n, aref_we_n, aref_ba, aref_addr
  );
endinterface

// File: rtl/aref_sched.sv
// DDR2 auto-refresh scheduler: tracks owed refreshes against tREFI and, once granted,
// issues PRE-all followed by back-to-back AREFs until the debt is flushed.
module aref_sched #(
  parameter int TREFI_CYC    = 1560,
  parameter int TRP_CYC      = 3,
  parameter int TRFC_CYC     = 26,
  parameter int MAX_POSTPONE = 8,
  parameter int RANKS        = 1,
  parameter int ADDR_BITS    = 13,
  parameter int BA_BITS      = 3
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         init_end,
  aref_sched_if.master bus,
  output logic [3:0]   debt,
  output logic         ovf_err
);
  localparam int CW   = $clog2(TREFI_CYC + 1);
  localparam int TMAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [3:0] DEBT_MAX = 4'(MAX_POSTPONE);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRE      = 3'd1;
  localparam logic [2:0] ST_WAIT_RP  = 3'd2;
  localparam logic [2:0] ST_AREF     = 3'd3;
  localparam logic [2:0] ST_WAIT_RFC = 3'd4;

  logic [CW-1:0]        cnt_r, cnt_nx_s;
  logic                 expire_s;
  logic [2:0]           state_r, state_nx_s;
  logic [TW-1:0]        tmr_r, tmr_nx_s;
  logic [3:0]           debt_r, debt_nx_s;
  logic                 ovf_r, ovf_nx_s;
  logic                 end_nx_s, cont_s, issue_s;
  logic [ADDR_BITS-1:0] addr_nx_s;

  // Interval counter and its wrap (expiry) pulse.
  always_comb begin
    expire_s = init_end && (cnt_r == CW'(TREFI_CYC - 1));
    if (!init_end || expire_s) begin
      cnt_nx_s = '0;
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end
  end

  // Sequencer next state; the final tRFC cycle is where we choose between another AREF and ending.
  always_comb begin
    state_nx_s = state_r;
    tmr_nx_s   = tmr_r;
    end_nx_s   = 1'b0;
    cont_s     = (debt_r != 4'd0) || expire_s;
    case (state_r)
      ST_IDLE: begin
        if ((debt_r != 4'd0) && bus.aref_gnt) begin
          state_nx_s = ST_PRE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (TRP_CYC <= 1) begin
          state_nx_s = ST_AREF;
        end else begin
          state_nx_s = ST_WAIT_RP;
          tmr_nx_s   = TW'(TRP_CYC - 1);
        end
      end
      ST_WAIT_RP: begin
        if (tmr_r <= TW'(1)) begin
          state_nx_s = ST_AREF;
        end else begin
          tmr_nx_s = tmr_r - TW'(1);
        end
      end
      ST_AREF: begin
        if (TRFC_CYC <= 1) begin
          if (cont_s) begin
            state_nx_s = ST_AREF;
          end else begin
            state_nx_s = ST_IDLE;
            end_nx_s   = 1'b1;
          end
        end else if (TRFC_CYC == 2) begin
          if (cont_s) begin
            state_nx_s = ST_WAIT_RFC;
            tmr_nx_s   = TW'(1);
          end else begin
            state_nx_s = ST_IDLE;
            end_nx_s   = 1'b1;
          end
        end else begin
          state_nx_s = ST_WAIT_RFC;
          tmr_nx_s   = TW'(TRFC_CYC - 1);
        end
      end
      ST_WAIT_RFC: begin
        if (tmr_r <= TW'(1)) begin
          state_nx_s = ST_AREF;
        end else if (tmr_r == TW'(2)) begin
          if (cont_s) begin
            tmr_nx_s = TW'(1);
          end else begin
            state_nx_s = ST_IDLE;
            end_nx_s   = 1'b1;
          end
        end else begin
          tmr_nx_s = tmr_r - TW'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        tmr_nx_s   = '0;
      end
    endcase
  end

  // Debt bookkeeping: expiry adds, an issued AREF subtracts, saturation flags overflow.
  always_comb begin
    issue_s   = (state_nx_s == ST_AREF);
    debt_nx_s = debt_r;
    ovf_nx_s  = ovf_r;
    case ({expire_s, issue_s})
      2'b10: begin
        if (debt_r == DEBT_MAX) begin
          ovf_nx_s = 1'b1;
        end else begin
          debt_nx_s = debt_r + 4'd1;
        end
      end
      2'b01:   debt_nx_s = debt_r - 4'd1;
      default: debt_nx_s = debt_r;
    endcase
    addr_nx_s     = '0;
    addr_nx_s[10] = (state_nx_s == ST_PRE);
  end

  // State, counters and registered outputs, all decoded from next state.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r           <= '0;
      state_r         <= ST_IDLE;
      tmr_r           <= '0;
      debt_r          <= 4'd0;
      ovf_r           <= 1'b0;
      bus.aref_req    <= 1'b0;
      bus.aref_urgent <= 1'b0;
      bus.aref_busy   <= 1'b0;
      bus.aref_end    <= 1'b0;
      bus.aref_cs_n   <= '0;
      bus.aref_ras_n  <= 1'b1;
      bus.aref_cas_n  <= 1'b1;
      bus.aref_we_n   <= 1'b1;
      bus.aref_ba     <= '0;
      bus.aref_addr   <= '0;
    end else begin
      cnt_r           <= cnt_nx_s;
      state_r         <= state_nx_s;
      tmr_r           <= tmr_nx_s;
      debt_r          <= debt_nx_s;
      ovf_r           <= ovf_nx_s;
      bus.aref_req    <= (debt_nx_s != 4'd0);
      bus.aref_urgent <= (debt_nx_s == DEBT_MAX);
      bus.aref_busy   <= (state_nx_s != ST_IDLE);
      bus.aref_end    <= end_nx_s;
      bus.aref_cs_n   <= '0;
      bus.aref_ras_n  <= !((state_nx_s == ST_PRE) || (state_nx_s == ST_AREF));
      bus.aref_cas_n  <= (state_nx_s != ST_AREF);
      bus.aref_we_n   <= (state_nx_s != ST_PRE);
      bus.aref_ba     <= '0;
      bus.aref_addr   <= addr_nx_s;
    end
  end

  assign debt    = debt_r;
  assign ovf_err = ovf_r;
endmodule

// File: tb/tb_aref_sched.sv
// Directed bench for aref_sched with TREFI=20, TRP=3, TRFC=10, MAX_POSTPONE=4, RANKS=2.
module tb_aref_sched;
  localparam int RANKS = 2;

  logic       ck = 1'b0;
  logic       rst_n = 1'b1;
  logic       init_end = 1'b0;
  logic [3:0] debt;
  logic       ovf_err;

  aref_sched_if #(.RANKS(RANKS), .ADDR_BITS(13), .BA_BITS(3)) bus ();

  aref_sched #(
    .TREFI_CYC(20), .TRP_CYC(3), .TRFC_CYC(10), .MAX_POSTPONE(4),
    .RANKS(RANKS), .ADDR_BITS(13), .BA_BITS(3)
  ) dut (
    .ck(ck), .rst_n(rst_n), .init_end(init_end), .bus(bus), .debt(debt), .ovf_err(ovf_err)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;

  // Command monitor: counts PRE/AREF/end events and illegal pin encodings.
  int cyc = 0;
  int pre_cnt = 0, aref_cnt = 0, end_cnt = 0, enc_bad = 0;
  int pre_cyc = 0, end_cyc = 0;
  int aref_q[$];
  logic [2:0] cmd;
  logic       enc_err;

  assign cmd = {bus.aref_ras_n, bus.aref_cas_n, bus.aref_we_n};
  assign enc_err = (bus.aref_cs_n !== 2'b00) || (bus.aref_ba !== 3'd0) ||
                   ((cmd === 3'b010) ? (bus.aref_addr !== 13'h0400) : (bus.aref_addr !== 13'h0000)) ||
                   !((cmd === 3'b111) || (cmd === 3'b010) || (cmd === 3'b001));

  always @(posedge ck) cyc <= cyc + 1;

  always @(negedge ck) begin
    if (enc_err) enc_bad <= enc_bad + 1;
    if (cmd === 3'b010) begin
      pre_cnt <= pre_cnt + 1;
      pre_cyc <= cyc;
    end
    if (cmd === 3'b001) begin
      aref_cnt <= aref_cnt + 1;
      aref_q.push_back(cyc);
    end
    if (bus.aref_end === 1'b1) begin
      end_cnt <= end_cnt + 1;
      end_cyc <= cyc;
    end
  end

  task automatic step();
    @(negedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.aref_gnt = 1'b0;
    init_end = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.aref_gnt = 1'b0;
    init_end = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (debt !== 4'd0) begin
      n_bad++; $display("FAIL reset_debt: got %0d want 0", debt);
    end
    repeat (3) step();
    n_cmp++;
    if ({bus.aref_req, bus.aref_urgent, bus.aref_busy, bus.aref_end, ovf_err} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.aref_req, bus.aref_urgent, bus.aref_busy, bus.aref_end, ovf_err});
    end
    n_cmp++;
    if ({bus.aref_cs_n, cmd, bus.aref_ba, bus.aref_addr} !== {2'b00, 3'b111, 3'd0, 13'h0000}) begin
      n_bad++;
      $display("FAIL reset_nop: got cs=%b cmd=%b ba=%0d addr=%h want cs=00 cmd=111 ba=0 addr=0",
               bus.aref_cs_n, cmd, bus.aref_ba, bus.aref_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_init_low();
    int p0;
    logic saw_req;
    do_reset();
    bus.aref_gnt = 1'b1;
    p0 = pre_cnt;
    saw_req = 1'b0;
    repeat (60) begin
      step();
      if (bus.aref_req !== 1'b0) saw_req = 1'b1;
    end
    n_cmp++;
    if (saw_req !== 1'b0) begin
      n_bad++; $display("FAIL init_low_req: got req seen=%b want 0", saw_req);
    end
    n_cmp++;
    if ((debt !== 4'd0) || (pre_cnt != p0)) begin
      n_bad++; $display("FAIL init_low_idle: got debt=%0d pres=%0d want debt=0 pres=0", debt, pre_cnt - p0);
    end
  endtask

  task automatic test_first_refresh();
    int c0, e, e0, qi;
    logic seen, done, busy_at_end;
    do_reset();
    bus.aref_gnt = 1'b1;
    e0 = end_cnt;
    qi = aref_q.size();
    c0 = cyc;
    init_end = 1'b1;
    seen = 1'b0;
    e = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (debt != 4'd0) begin
        seen = 1'b1;
        e = cyc;
      end
    end
    n_cmp++;
    if (!seen || (e != c0 + 20)) begin
      n_bad++; $display("FAIL first_expiry: got seen=%b cycle=%0d want cycle=%0d", seen, e, c0 + 20);
    end
    done = 1'b0;
    busy_at_end = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (end_cnt != e0) begin
        done = 1'b1;
        busy_at_end = bus.aref_busy;
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL first_end_timeout: got no aref_end want one within 30 cycles");
    end
    n_cmp++;
    if (pre_cyc != e + 1) begin
      n_bad++; $display("FAIL first_pre_cycle: got %0d want %0d", pre_cyc, e + 1);
    end
    n_cmp++;
    if ((aref_q.size() != qi + 1) || (aref_q[qi] != e + 4)) begin
      n_bad++; $display("FAIL first_aref: got count=%0d cycle=%0d want count=1 cycle=%0d",
                        aref_q.size() - qi, (aref_q.size() > qi) ? aref_q[qi] : -1, e + 4);
    end
    n_cmp++;
    if ((end_cyc != e + 13) || (busy_at_end !== 1'b0) || (debt !== 4'd0)) begin
      n_bad++; $display("FAIL first_end: got cycle=%0d busy=%b debt=%0d want cycle=%0d busy=0 debt=0",
                        end_cyc, busy_at_end, debt, e + 13);
    end
    init_end = 1'b0;
  endtask

  task automatic test_postpone();
    int p0, a0, e0, want;
    logic done;
    do_reset();
    p0 = pre_cnt;
    init_end = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      repeat (20) step();
      want = (i > 4) ? 4 : i;
      n_cmp++;
      if ((debt !== 4'(want)) || (bus.aref_urgent !== (i >= 4)) || (ovf_err !== (i >= 5))) begin
        n_bad++; $display("FAIL postpone_%0d: got debt=%0d urgent=%b ovf=%b want debt=%0d urgent=%b ovf=%b",
                          i, debt, bus.aref_urgent, ovf_err, want, (i >= 4), (i >= 5));
      end
    end
    n_cmp++;
    if ((pre_cnt != p0) || (bus.aref_req !== 1'b1) || (bus.aref_busy !== 1'b0)) begin
      n_bad++; $display("FAIL postpone_nogrant: got pres=%0d req=%b busy=%b want 0 1 0",
                        pre_cnt - p0, bus.aref_req, bus.aref_busy);
    end
    a0 = aref_cnt;
    e0 = end_cnt;
    bus.aref_gnt = 1'b1;
    init_end = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      step();
      if (end_cnt != e0) done = 1'b1;
    end
    n_cmp++;
    if (!done || (aref_cnt - a0 != 4) || (debt !== 4'd0) || (ovf_err !== 1'b1) || (bus.aref_urgent !== 1'b0)) begin
      n_bad++; $display("FAIL urgent_flush: got end=%b arefs=%0d debt=%0d ovf=%b urgent=%b want 1 4 0 1 0",
                        done, aref_cnt - a0, debt, ovf_err, bus.aref_urgent);
    end
  endtask

  task automatic test_flush3();
    int c0, p0, a0, e0, b0, qi;
    logic done;
    do_reset();
    c0 = cyc;
    init_end = 1'b1;
    repeat (60) step();
    n_cmp++;
    if ((debt !== 4'd3) || (bus.aref_urgent !== 1'b0)) begin
      n_bad++; $display("FAIL flush3_debt: got debt=%0d urgent=%b want 3 0", debt, bus.aref_urgent);
    end
    p0 = pre_cnt; a0 = aref_cnt; e0 = end_cnt; b0 = enc_bad; qi = aref_q.size();
    bus.aref_gnt = 1'b1;
    init_end = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (end_cnt != e0) done = 1'b1;
    end
    repeat (5) step();
    n_cmp++;
    if (!done || (pre_cnt - p0 != 1) || (pre_cyc != c0 + 61) || (end_cnt - e0 != 1) || (end_cyc != c0 + 93)) begin
      n_bad++; $display("FAIL flush3_frame: got end=%b pres=%0d pre_cyc=%0d ends=%0d end_cyc=%0d want 1 1 %0d 1 %0d",
                        done, pre_cnt - p0, pre_cyc - c0, end_cnt - e0, end_cyc - c0, 61, 93);
    end
    n_cmp++;
    if ((aref_cnt - a0 != 3) || (aref_q.size() < qi + 3)) begin
      n_bad++; $display("FAIL flush3_count: got %0d arefs want 3", aref_cnt - a0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (aref_q[qi + k] != c0 + 64 + 10 * k) begin
          n_bad++; $display("FAIL flush3_aref%0d: got cycle %0d want %0d", k, aref_q[qi + k] - c0, 64 + 10 * k);
        end
      end
    end
    n_cmp++;
    if ((enc_bad != b0) || (debt !== 4'd0)) begin
      n_bad++; $display("FAIL flush3_pins: got bad_encodings=%0d debt=%0d want 0 0", enc_bad - b0, debt);
    end
  endtask

  task automatic test_coincident();
    int c0, p0, a0, e0, qi;
    logic done;
    do_reset();
    c0 = cyc;
    init_end = 1'b1;
    repeat (36) step();
    n_cmp++;
    if (debt !== 4'd1) begin
      n_bad++; $display("FAIL coinc_pre_debt: got %0d want 1", debt);
    end
    p0 = pre_cnt; a0 = aref_cnt; e0 = end_cnt; qi = aref_q.size();
    bus.aref_gnt = 1'b1;
    repeat (4) step();
    n_cmp++;
    if ((cmd !== 3'b001) || (debt !== 4'd1)) begin
      n_bad++; $display("FAIL coinc_aref_debt: got cmd=%b debt=%0d want cmd=001 debt=1", cmd, debt);
    end
    init_end = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (end_cnt != e0) done = 1'b1;
    end
    n_cmp++;
    if (!done || (aref_cnt - a0 != 2) || (aref_q.size() < qi + 2) || (end_cyc != c0 + 59)) begin
      n_bad++; $display("FAIL coinc_extra: got end=%b arefs=%0d end_cyc=%0d want 1 2 59",
                        done, aref_cnt - a0, end_cyc - c0);
    end else begin
      n_cmp++;
      if (aref_q[qi + 1] != c0 + 50) begin
        n_bad++; $display("FAIL coinc_second: got cycle %0d want 50", aref_q[qi + 1] - c0);
      end
    end
    repeat (10) step();
    n_cmp++;
    if ((pre_cnt - p0 != 1) || (bus.aref_req !== 1'b0) || (debt !== 4'd0)) begin
      n_bad++; $display("FAIL coinc_gnt_ignored: got pres=%0d req=%b debt=%0d want 1 0 0",
                        pre_cnt - p0, bus.aref_req, debt);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    do_reset();
    init_end = 1'b1;
    repeat (20) step();
    bus.aref_gnt = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ((bus.aref_busy !== 1'b1) || (cmd !== 3'b111)) begin
      n_bad++; $display("FAIL rst_mid_waitrp: got busy=%b cmd=%b want 1 111", bus.aref_busy, cmd);
    end
    a0 = aref_cnt;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.aref_busy, bus.aref_req, bus.aref_end, cmd, bus.aref_addr} !== {3'b000, 3'b111, 13'h0000} ||
        (debt !== 4'd0)) begin
      n_bad++; $display("FAIL rst_mid_abort: got busy=%b req=%b end=%b cmd=%b addr=%h debt=%0d want 0 0 0 111 0 0",
                        bus.aref_busy, bus.aref_req, bus.aref_end, cmd, bus.aref_addr, debt);
    end
    repeat (6) step();
    rst_n = 1'b1;
    bus.aref_gnt = 1'b0;
    init_end = 1'b0;
    repeat (5) step();
    n_cmp++;
    if ((aref_cnt != a0) || (debt !== 4'd0)) begin
      n_bad++; $display("FAIL rst_mid_noaref: got arefs=%0d debt=%0d want 0 0", aref_cnt - a0, debt);
    end
  endtask

  initial begin
    bus.aref_gnt = 1'b0;
    test_reset();
    test_init_low();
    test_first_refresh();
    test_postpone();
    test_flush3();
    test_coincident();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want summary before 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/aref_sched.md
AREF_SCHED -- requirements
Module: aref_sched

Interface
REQ-001 Parameter TREFI_CYC, default 1560, refresh interval in ck cycles.
REQ-002 Parameter TRP_CYC, default 3, PRE-all to AREF spacing in cycles (min 1).
REQ-003 Parameter TRFC_CYC, default 26, AREF to next command spacing in cycles (min 1).
REQ-004 Parameter MAX_POSTPONE, default 8, maximum owed refreshes (1..15).
REQ-005 Parameter RANKS, default 1, chip-select count (1..4).
REQ-006 Parameter ADDR_BITS, default 13; BA_BITS, default 3.
REQ-007 ck  input  1  controller clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 init_end  input  1  level; high once DDR2 initialisation is complete.
REQ-010 aref_gnt  input  1  arbiter grant; bus idle, all banks may be closed.
REQ-011 aref_req  output  1  refresh owed (debt > 0).
REQ-012 aref_urgent  output  1  debt == MAX_POSTPONE; arbiter must grant next.
REQ-013 aref_busy  output  1  block owns the command bus.
REQ-014 aref_end  output  1  one-cycle pulse; refresh sequence finished.
REQ-015 aref_cs_n  output  RANKS  per-rank chip select.
REQ-016 aref_ras_n, aref_cas_n, aref_we_n  output  1 each  command bits.
REQ-017 aref_ba  output  BA_BITS  bank address, always 0.
REQ-018 aref_addr  output  ADDR_BITS  address; bit 10 = 1 during PRE-all, else 0.
REQ-019 debt  output  4  current owed-refresh count.
REQ-020 ovf_err  output  1  sticky; set on tREFI expiry while debt == MAX_POSTPONE.

Function
REQ-021 Interval counter held at 0 while init_end low; else counts 0..TREFI_CYC-1, wraps, and produces one expiry pulse on the wrap cycle.
REQ-022 Expiry increments debt; each issued AREF decrements debt; expiry and AREF in the same cycle leave debt unchanged.
REQ-023 Expiry at debt == MAX_POSTPONE with no AREF that cycle: debt saturates and ovf_err sets; ovf_err clears only on reset.
REQ-024 States: IDLE, PRE, WAIT_RP, AREF, WAIT_RFC.
REQ-025 IDLE: NOP driven, busy 0; on aref_req && aref_gnt at edge t, state goes to PRE and busy = 1 from cycle t+1.
REQ-026 aref_gnt is ignored outside IDLE and when debt == 0.
REQ-027 PRE (one cycle): all cs_n = 0, ras_n = 0, cas_n = 1, we_n = 0, addr[10] = 1; then WAIT_RP.
REQ-028 AREF issues exactly TRP_CYC cycles after PRE: all cs_n = 0, ras_n = 0, cas_n = 0, we_n = 1; one cycle.
REQ-029 After AREF, WAIT_RFC lasts TRFC_CYC-1 NOP cycles; then if debt > 0 (post-decrement, including new expiries) another AREF issues with no further PRE.
REQ-030 When debt == 0 at end of WAIT_RFC: aref_end pulses for one cycle, busy drops that same cycle, state returns to IDLE.
REQ-031 Consecutive AREF commands are exactly TRFC_CYC cycles apart; the sequence flushes all owed refreshes.
REQ-032 NOP encoding, all non-command cycles: all cs_n = 0, ras_n = cas_n = we_n = 1, ba = 0, addr = 0.
REQ-033 All command outputs are registered; no combinational path from inputs to outputs.
REQ-034 aref_req = (debt != 0) and aref_urgent = (debt == MAX_POSTPONE), both registered with debt.
REQ-035 init_end falling mid-sequence: the current sequence completes normally, while the interval counter clears and holds.

Reset
REQ-036 While rst_n low: state IDLE, debt 0, interval counter 0, aref_req/aref_urgent/aref_busy/aref_end/ovf_err 0, NOP driven, ba = 0, addr = 0.
REQ-037 Reset asserted mid-sequence aborts immediately to the reset values; no further command issues.

Verification (TREFI_CYC = 20, TRP_CYC = 3, TRFC_CYC = 10, MAX_POSTPONE = 4, RANKS = 2)
REQ-038 init_end high with aref_gnt tied 1 -> PRE at cycle e+1 after first expiry e, AREF at e+4, aref_end at e+13, debt returns to 0.
REQ-039 aref_gnt held 0 for 100 cycles -> debt rises to 4, aref_urgent = 1, ovf_err = 1 after the 5th expiry.
REQ-040 Debt 3, then grant -> one PRE, three AREFs at spacing 10 cycles, single aref_end pulse, and aref_cs_n = 2'b00 on every command.
REQ-041 Expiry coincident with an AREF cycle -> debt unchanged that cycle, and one extra AREF appended to the sequence.
REQ-042 rst_n pulsed low during WAIT_RP -> outputs at reset values, with no AREF issued and debt = 0.
REQ-043 init_end low -> no expiries and aref_req stays 0, regardless of aref_gnt.
